// File: rtl/mul_rr_scheduler_if.sv
// Request/response bundle between requesters and the shared multiplier scheduler.
interface mul_rr_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 5,
   parameter int IDW   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] op_a_flat;
   logic [N_REQ*WIDTH-1:0] op_b_flat;
   logic [N_REQ-1:0]       gnt;
   logic                   busy;
   logic                   done;
   logic [IDW-1:0]         done_id;
   logic [2*WIDTH-1:0]     mul_out;

   modport master (
      output req, op_a_flat, op_b_flat,
      input  gnt, busy, done, done_id, mul_out
   );

   modport slave (
      input  req, op_a_flat, op_b_flat,
      output gnt, busy, done, done_id, mul_out
   );
endinterface

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end for one shared shift-add multiplier (one partial product per cycle).
module mul_rr_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 5,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   mul_rr_scheduler_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [IDW-1:0]   r_ptr, r_id, r_did, w_win, w_idx;
   logic             w_found, w_last;
   logic [WIDTH-1:0] r_a, r_b;
   logic [PW-1:0]    r_acc, r_mul, w_pp, w_sum;
   logic [CW-1:0]    r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic             r_done;

   // Scan from the pointer upward with wrap; first set bit wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   assign w_pp   = r_b[r_cnt] ? (PW'(r_a) << r_cnt) : '0;
   assign w_sum  = r_acc + w_pp;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_found) w_next = S_CALC;
         S_CALC:  if (w_last)  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr  <= '0;
         r_id   <= '0;
         r_did  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_mul  <= '0;
         r_cnt  <= '0;
         r_gnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (w_found) begin
               r_gnt <= N_REQ'(1) << w_win;
               r_id  <= w_win;
               r_a   <= bus.op_a_flat[w_win*WIDTH +: WIDTH];
               r_b   <= bus.op_b_flat[w_win*WIDTH +: WIDTH];
               r_ptr <= (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
               r_acc <= '0;
               r_cnt <= '0;
            end
            S_CALC: begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
               // mul_out and done_id only move on completion so they hold between products
               if (w_last) begin
                  r_mul  <= w_sum;
                  r_did  <= r_id;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = r_done;
   assign bus.done_id = r_did;
   assign bus.mul_out = r_mul;
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Random + directed bench for mul_rr_scheduler against a transaction-level reference model.
module tb_mul_rr_scheduler;
   localparam int N  = 4;
   localparam int W  = 5;
   localparam int IW = 2;
   localparam int PW = 10;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mul_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .IDW(IW)) bus_if ();
   mul_rr_scheduler #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: at each edge either arbitrate, count down the fixed latency, or idle.
   logic [N-1:0]  m_gnt  = '0;
   logic          m_busy = 1'b0, m_done = 1'b0;
   logic [IW-1:0] m_id   = '0;
   logic [PW-1:0] m_mul  = '0;
   int m_ptr = 0, m_win = 0, m_step = 0, m_phase = 0;
   int unsigned m_prod = 0;
   bit started = 1'b0;

   always @(posedge clk) begin
      logic [N-1:0] rq;
      int j;
      started = 1'b1;
      rq      = bus_if.req;
      m_gnt   = '0;
      m_done  = 1'b0;
      if (!reset) begin
         m_busy = 1'b0; m_id = '0; m_mul = '0; m_ptr = 0; m_phase = 0;
      end else if (m_phase == 0) begin
         m_win = -1;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (m_win < 0 && rq[j]) m_win = j;
         end
         if (m_win >= 0) begin
            m_prod  = int'(bus_if.op_a_flat[m_win*W +: W]) * int'(bus_if.op_b_flat[m_win*W +: W]);
            m_gnt   = N'(1) << m_win;
            m_ptr   = (m_win + 1) % N;
            m_step  = 0;
            m_phase = 1;
            m_busy  = 1'b1;
         end
      end else if (m_phase == 1) begin
         m_step++;
         if (m_step == W) begin
            m_done = 1'b1; m_id = IW'(m_win); m_mul = PW'(m_prod); m_phase = 2;
         end
      end else begin
         m_busy = 1'b0; m_phase = 0;
      end
   end

   int g_q[$];
   int d_id_q[$];
   int d_mul_q[$];

   always @(negedge clk) begin
      if (started) begin
         n_cmp++;
         if ({bus_if.gnt, bus_if.busy, bus_if.done, bus_if.done_id, bus_if.mul_out} !==
             {m_gnt, m_busy, m_done, m_id, m_mul}) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got gnt=%b busy=%b done=%b id=%0d mul=%0d, expected gnt=%b busy=%b done=%b id=%0d mul=%0d",
                     $time, bus_if.gnt, bus_if.busy, bus_if.done, bus_if.done_id, bus_if.mul_out,
                     m_gnt, m_busy, m_done, m_id, m_mul);
         end
         for (int k = 0; k < N; k++) if (bus_if.gnt[k] === 1'b1) g_q.push_back(k);
         if (bus_if.done === 1'b1) begin
            d_id_q.push_back(int'(bus_if.done_id));
            d_mul_q.push_back(int'(bus_if.mul_out));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus_if.op_a_flat[i*W +: W] = W'(a);
      bus_if.op_b_flat[i*W +: W] = W'(b);
   endtask

   task automatic wait_gnt(input int i);
      int t;
      t = 0;
      while (bus_if.gnt[i] !== 1'b1 && t < 100) begin tick(1); t++; end
      if (t >= 100) chk("gnt_timeout", 32'(t), 0);
   endtask

   task automatic wait_done(output int lat);
      int t;
      t = 0;
      while (bus_if.done !== 1'b1 && t < 100) begin tick(1); t++; end
      if (t >= 100) chk("done_timeout", 32'(t), 0);
      lat = t;
   endtask

   // One full transaction for requester i; lat = cycles from gnt to done.
   task automatic do_req(input int i, input int a, input int b,
                         output int gid, output int prod, output int lat);
      set_op(i, a, b);
      bus_if.req[i] = 1'b1;
      wait_gnt(i);
      bus_if.req[i] = 1'b0;
      wait_done(lat);
      gid  = int'(bus_if.done_id);
      prod = int'(bus_if.mul_out);
      tick(1);
   endtask

   int gid, prod, lat;
   int ea[4] = '{31, 0, 31, 1};
   int eb[4] = '{31, 31, 0, 1};
   int ep[4] = '{961, 0, 0, 1};
   int ord[5] = '{0, 1, 2, 3, 0};
   int pr[5]  = '{2, 12, 30, 56, 2};

   initial begin
      bus_if.req       = '0;
      bus_if.op_a_flat = '0;
      bus_if.op_b_flat = '0;
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(5);
      chk("reset_busy", 32'(bus_if.busy), 0);
      chk("reset_gnt", 32'(bus_if.gnt), 0);
      chk("reset_mul", 32'(bus_if.mul_out), 0);
      chk("reset_id", 32'(bus_if.done_id), 0);

      // single request 13x11, exact cycle timing
      set_op(0, 13, 11);
      bus_if.req = 4'b0001;
      tick(1);
      chk("t2_gnt", 32'(bus_if.gnt), 1);
      chk("t2_busy", 32'(bus_if.busy), 1);
      bus_if.req = '0;
      tick(4);
      chk("t2_nodone_early", 32'(bus_if.done), 0);
      tick(1);
      chk("t2_done", 32'(bus_if.done), 1);
      chk("t2_mul", 32'(bus_if.mul_out), 143);
      chk("t2_id", 32'(bus_if.done_id), 0);
      chk("t2_busy_done", 32'(bus_if.busy), 1);
      tick(1);
      chk("t2_idle", 32'(bus_if.busy), 0);
      chk("t2_hold", 32'(bus_if.mul_out), 143);

      // operand extremes on requester 2
      for (int e = 0; e < 4; e++) begin
         do_req(2, ea[e], eb[e], gid, prod, lat);
         chk("t3_prod", 32'(prod), 32'(ep[e]));
         chk("t3_id", 32'(gid), 2);
         chk("t3_lat", 32'(lat), 5);
      end

      // all requesting from pointer 0
      reset = 1'b0; tick(1); reset = 1'b1;
      g_q.delete(); d_id_q.delete(); d_mul_q.delete();
      for (int i = 0; i < 4; i++) set_op(i, 2*i + 1, 2*i + 2);
      bus_if.req = 4'b1111;
      begin
         int t;
         t = 0;
         while (d_id_q.size() < 5 && t < 300) begin tick(1); t++; end
         if (t >= 300) chk("t4_timeout", 32'(t), 0);
      end
      bus_if.req = '0;
      tick(3);
      for (int k = 0; k < 5; k++) begin
         chk("t4_gnt_order", (k < g_q.size()) ? 32'(g_q[k]) : 32'hFFFF, 32'(ord[k]));
         chk("t4_id", (k < d_id_q.size()) ? 32'(d_id_q[k]) : 32'hFFFF, 32'(ord[k]));
         chk("t4_prod", (k < d_mul_q.size()) ? 32'(d_mul_q[k]) : 32'hFFFF, 32'(pr[k]));
      end

      // operand change after grant is ignored; late request waits for IDLE
      set_op(1, 6, 5);
      bus_if.req[1] = 1'b1;
      wait_gnt(1);
      bus_if.req[1] = 1'b0;
      tick(2);
      set_op(1, 9, 5);
      set_op(3, 4, 4);
      bus_if.req[3] = 1'b1;
      wait_done(lat);
      chk("t5_prod", 32'(bus_if.mul_out), 30);
      chk("t5_id", 32'(bus_if.done_id), 1);
      tick(1);
      chk("t5_no_gnt_yet", 32'(bus_if.gnt), 0);
      tick(1);
      chk("t5_gnt3", 32'(bus_if.gnt), 4'b1000);
      bus_if.req[3] = 1'b0;
      wait_done(lat);
      chk("t5_prod3", 32'(bus_if.mul_out), 16);
      tick(2);

      // reset aborts a multiply in flight
      d_id_q.delete(); g_q.delete();
      set_op(0, 20, 20);
      bus_if.req[0] = 1'b1;
      wait_gnt(0);
      bus_if.req[0] = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(10);
      chk("t6_no_done", 32'(d_id_q.size()), 0);
      chk("t6_mul", 32'(bus_if.mul_out), 0);
      chk("t6_busy", 32'(bus_if.busy), 0);
      g_q.delete();
      do_req(2, 7, 3, gid, prod, lat);
      chk("t6_gnt", (g_q.size() > 0) ? 32'(g_q[0]) : 32'hFFFF, 2);
      chk("t6_prod", 32'(prod), 21);
      chk("t6_id", 32'(gid), 2);

      // random traffic, including occasional resets
      for (int c = 0; c < 600; c++) begin
         bus_if.req       = N'($urandom);
         bus_if.op_a_flat = (N*W)'($urandom);
         bus_if.op_b_flat = (N*W)'($urandom);
         reset            = ($urandom_range(0, 99) != 0);
         tick(1);
      end
      reset      = 1'b1;
      bus_if.req = '0;
      tick(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
